// File: rtl/bus_pkg.sv
// Shared bus definitions: target encoding, address prefixes, arbiter states
// and the high-address decoder used by the arbiter and the slave muxes.
package bus_pkg;

  typedef enum logic [1:0] {
    TGT_S1 = 2'd0,
    TGT_S2 = 2'd1,
    TGT_S3 = 2'd2,
    TGT_BB = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  // Prefixes on addr[15:11]; shorter prefixes cover larger windows.
  localparam logic [4:0] PFX_S1 = 5'b00000;
  localparam logic [3:0] PFX_S2 = 4'b0001;
  localparam logic [3:0] PFX_S3 = 4'b0010;
  localparam logic [1:0] PFX_BB = 2'b11;

  typedef struct packed {
    logic    valid;
    target_e tgt;
  } dec_t;

  function automatic dec_t addr_decode(input logic [4:0] addr_hi);
    dec_t r;
    r.valid = 1'b1;
    r.tgt   = TGT_S1;
    if (addr_hi == PFX_S1)           r.tgt = TGT_S1;
    else if (addr_hi[4:1] == PFX_S2) r.tgt = TGT_S2;
    else if (addr_hi[4:1] == PFX_S3) r.tgt = TGT_S3;
    else if (addr_hi[4:3] == PFX_BB) r.tgt = TGT_BB;
    else                             r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr,
// wrapping around; one-hot and index forms of the winner.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && elig[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the serial system bus: grants one master at a time
// to a ready target, holds until done/abort, and times out hung transfers.
//
// state       | meaning
// ARB_IDLE    | scan eligible requesters from the rr pointer, grant the winner
// ARB_BUSY    | grant held; watchdog runs until owner done, abort or expiry
// ARB_RELEASE | one-cycle mandatory gap after every release
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_M-1:0]                        m_req,
  input  logic [NUM_M*5-1:0]                      m_addr_hi,
  input  logic [NUM_M-1:0]                        m_done,
  input  logic [3:0]                              s_ready,
  output logic [NUM_M-1:0]                        m_grant,
  output logic [NUM_M-1:0]                        m_dec_err,
  output logic [3:0]                              s_sel,
  output logic [((NUM_M > 1) ? $clog2(NUM_M) : 1)-1:0] owner,
  output logic                                    bus_busy,
  output logic                                    timeout_err
);

  localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [NUM_M-1:0] dec_err_q, dec_err_d;
  logic [3:0]       sel_q, sel_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             busy_q, busy_d;
  logic             tout_q, tout_d;

  dec_t             dec [NUM_M];
  logic [NUM_M-1:0] elig;
  logic [NUM_M-1:0] bad_addr;
  logic [NUM_M-1:0] pick_gnt;
  logic [OW-1:0]    pick_idx;
  logic             pick_any;
  logic [1:0]       win_tgt;
  logic             own_done;
  logic             own_req;
  logic             release_now;
  logic             expire_now;

  always_comb begin
    elig     = '0;
    bad_addr = '0;
    for (int i = 0; i < NUM_M; i++) begin
      dec[i]      = addr_decode(m_addr_hi[i*5 +: 5]);
      bad_addr[i] = m_req[i] & ~dec[i].valid;
      elig[i]     = m_req[i] & dec[i].valid & s_ready[dec[i].tgt];
    end
  end

  rr_pick #(.N(NUM_M), .IW(OW)) u_pick (
    .elig (elig),
    .ptr  (ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Winner's target recovered from the one-hot grant to avoid out-of-range indexing.
  always_comb begin
    win_tgt = 2'd0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_gnt[i]) win_tgt = win_tgt | dec[i].tgt;
    end
  end

  assign own_done    = m_done[owner_q];
  assign own_req     = m_req[owner_q];
  assign expire_now  = (wdog_q == CNT_W'(TIMEOUT - 1));
  assign release_now = own_done | ~own_req | expire_now;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    busy_d    = busy_q;
    tout_d    = 1'b0;
    dec_err_d = '0;
    unique case (state_q)
      ARB_IDLE: begin
        // Throttle repeats: a master that pulsed last cycle stays quiet this cycle.
        dec_err_d = bad_addr & ~dec_err_q;
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          sel_d   = 4'b0001 << win_tgt;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          wdog_d  = '0;
        end
      end
      ARB_BUSY: begin
        if (release_now) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
          sel_d   = 4'b0000;
          busy_d  = 1'b0;
          owner_d = '0;
          wdog_d  = '0;
          ptr_d   = (owner_q == OW'(NUM_M - 1)) ? '0 : owner_q + 1'b1;
          tout_d  = ~own_done & own_req;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      wdog_q    <= '0;
      busy_q    <= 1'b0;
      tout_q    <= 1'b0;
      dec_err_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      busy_q    <= busy_d;
      tout_q    <= tout_d;
      dec_err_q <= dec_err_d;
    end
  end

  assign m_grant     = grant_q;
  assign m_dec_err   = dec_err_q;
  assign s_sel       = sel_q;
  assign owner       = owner_q;
  assign bus_busy    = busy_q;
  assign timeout_err = tout_q;

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin bus arbiter that shares the serial system bus between NUM_M master ports.
- Decodes each requester's high address bits to one of four targets: slave 1, slave 2, slave 3 or the bus bridge.
- Grants the bus only when the target slave port reports ready, and holds ownership until the master signals completion.
- Recovers from a hung transaction with a watchdog timeout. Sits between the master_port instances and the bus mux/slave_port_v2 instances.

Parameters:
- NUM_M, 2, number of master ports (2..4).
- TIMEOUT, 256, maximum cycles a grant may be held without m_done (>=4).
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width (derived).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  NUM_M  per-master bus request, level, held until m_grant or abandoned.
- m_addr_hi  in  NUM_M*5  per-master address bits [15:11], stable while m_req is high.
- m_done  in  NUM_M  per-master end-of-transaction pulse; only the owner's bit is honoured.
- s_ready  in  4  per-target idle/ready: [0] slave1, [1] slave2, [2] slave3, [3] bus bridge.
- m_grant  out  NUM_M  one-hot grant, registered.
- m_dec_err  out  NUM_M  one-cycle pulse: request address maps to no target.
- s_sel  out  4  one-hot target select, registered, valid while a grant is held.
- owner  out  $clog2(NUM_M) (min 1)  index of the current owner, 0 when idle.
- bus_busy  out  1  high in the BUSY state.
- timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr pointer = 0; watchdog = 0.
- Decode of addr[15:11]:
  - 00000 -> target 0 (slave1, 2 KB).
  - 0001x -> target 1 (slave2, 4 KB).
  - 0010x -> target 2 (slave3, 4 KB).
  - 11xxx -> target 3 (bridge, 16 KB).
  - Any other value is a decode error.
- FSM IDLE -> BUSY -> RELEASE -> IDLE.
- IDLE eligibility: master i is eligible when m_req[i]=1, its decode is valid and s_ready[target]=1.
  - Scan from the rr pointer upward with wrap-around; the first eligible master wins.
  - On the next edge: m_grant, s_sel, owner and bus_busy are registered, state -> BUSY, watchdog cleared.
  - Latency: request seen in cycle N -> grant visible in cycle N+1.
- Decode error in IDLE: pulse m_dec_err[i] for 1 cycle. Repeat the pulse at most once every 2 cycles while m_req stays high with the bad address. Never grant that master and never block other masters.
- Target not ready: that requester is skipped this cycle with no error and re-evaluated every cycle.
- Owner asserts m_done in BUSY: state -> RELEASE on the next edge. m_grant, s_sel and bus_busy drop, and the rr pointer moves to (owner+1) mod NUM_M.
- RELEASE always lasts one cycle, then IDLE. This is a mandatory idle gap: earliest new grant is 3 cycles after m_done.
- Owner drops m_req in BUSY without m_done: treated as an abort, same as m_done, no error.
- m_done from a non-owner: ignored.
- Watchdog:
  - Increments every BUSY cycle.
  - When it reaches TIMEOUT-1 with no m_done: pulse timeout_err, go to RELEASE and advance the pointer as for a normal release.
  - m_done in the same cycle as the expiry: m_done wins, no timeout_err.
- s_ready falling while BUSY: ignored; the grant is held.
- New requests arriving while BUSY: queued implicitly by level; no grant change until release.
- Reset during BUSY: the grant drops immediately (async) and the pointer returns to 0.

Decomposition:
- Shared package bus_pkg holds:
  - target_e enum (TGT_S1, TGT_S2, TGT_S3, TGT_BB);
  - address-prefix constants;
  - arb_state_e enum (ARB_IDLE, ARB_BUSY, ARB_RELEASE);
  - the decode function addr_decode(addr_hi) -> {valid, target}.
- One sub-module, rr_pick: a combinational round-robin priority picker (eligible vector plus pointer in, one-hot winner plus index plus any out), reused later for the multi-slave split scheduler.

Test Plan:
- Single request: NUM_M=2, s_ready=4'hF, m_req=01, addr_hi=5'b11010 -> next cycle m_grant=01, s_sel=1000, bus_busy=1. m_done[0] pulse -> grant 0 after 1 cycle, bus_busy 0.
- Fairness: both masters request continuously, targets slave2 (00010) and slave3 (00100), m_done after 5 cycles each -> grants alternate 01,10,01,10 with a 1-cycle RELEASE gap between them.
- Decode error and not-ready: m0 addr_hi=5'b01000, m1 addr_hi=5'b00000 with s_ready[0]=0 -> m_dec_err[0] pulses, no grant. Raise s_ready[0] -> m1 granted the next cycle with s_sel=0001.
- Timeout: TIMEOUT=16, m0 granted and m_done never asserted -> timeout_err pulses exactly 16 cycles after the grant, grant released, m1 granted next if requesting.
- Corner cases:
  - m_done and watchdog expiry in the same cycle -> no timeout_err.
  - Non-owner m_done -> no effect.
  - Owner drops m_req mid-grant -> release with no error.
- Reset in BUSY: assert rst mid-grant -> all outputs 0 asynchronously. After deassertion with both masters requesting, m0 is granted first (pointer reset).
